rsa_core_modmul: RTL and testbench



---
 rtl/rsa_core_modmul.sv | 174 +++++++++++++++++
 tb/tb_rsa_core_modmul.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_core_modmul.sv
// Modular multiplier C = (X * Y) mod N using MSB-first interleaved double/add with per-step reduction.
// Optional build macro RSA_MODMUL_CYCLE_CNT_EN adds the 16-bit mod_cycles latency report port.
module rsa_core_modmul #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter logic        START      = 1'b1
) (
   input  logic                  mod_clk,
   input  logic                  mod_rst,
   input  logic                  mod_start,
   input  logic [DATA_WIDTH-1:0] mod_x,
   input  logic [DATA_WIDTH-1:0] mod_y,
   input  logic [DATA_WIDTH-1:0] mod_n,
   output logic                  mod_busy,
   output logic                  mod_done,
   output logic                  mod_err,
   output logic [DATA_WIDTH-1:0] mod_c
`ifdef RSA_MODMUL_CYCLE_CNT_EN
   ,
   output logic [15:0]           mod_cycles
`endif
);

   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned AW    = W + 1;
   localparam int unsigned TW    = W + 2;
   localparam int unsigned CNT_W = $clog2(W + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_DOUBLE = 3'd2,
      S_ADD    = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic [W-1:0]     x_reg, y_reg, n_reg;
   logic [W-1:0]     x_nxt, y_nxt, n_nxt;
   logic [AW-1:0]    acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             busy_nxt, done_nxt, err_nxt;
   logic [W-1:0]     c_nxt;

`ifdef RSA_MODMUL_CYCLE_CNT_EN
   logic [15:0] cyc_cnt, cyc_cnt_nxt, cycles_nxt;
`endif

   logic          start_hit_c;
   logic          range_bad_c;
   logic [TW-1:0] n_ext_c, t_dbl_c, t_add_c;
   logic [AW-1:0] red_dbl_c, red_add_c;

   assign start_hit_c = (mod_start == START);
   assign range_bad_c = (n_reg == '0) || (x_reg >= n_reg) || (y_reg >= n_reg);

   // Both step results stay below 2N because acc < N holds between steps
   assign n_ext_c   = TW'(n_reg);
   assign t_dbl_c   = {1'b0, acc, 1'b0};
   assign t_add_c   = TW'(acc) + (y_reg[W-1] ? TW'(x_reg) : TW'(0));
   assign red_dbl_c = (t_dbl_c >= n_ext_c) ? AW'(t_dbl_c - n_ext_c) : AW'(t_dbl_c);
   assign red_add_c = (t_add_c >= n_ext_c) ? AW'(t_add_c - n_ext_c) : AW'(t_add_c);

   // State register
   always_ff @(posedge mod_clk or negedge mod_rst) begin
      if (!mod_rst) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start_hit_c) state_nxt = S_CHECK;
         S_CHECK:  state_nxt = range_bad_c ? S_ERROR : S_DOUBLE;
         S_DOUBLE: state_nxt = S_ADD;
         S_ADD:    state_nxt = (cnt == CNT_W'(1)) ? S_DONE : S_DOUBLE;
         S_DONE:   state_nxt = S_IDLE;
         S_ERROR:  state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      x_nxt    = x_reg;
      y_nxt    = y_reg;
      n_nxt    = n_reg;
      acc_nxt  = acc;
      cnt_nxt  = cnt;
      busy_nxt = mod_busy;
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
      c_nxt    = mod_c;
`ifdef RSA_MODMUL_CYCLE_CNT_EN
      cyc_cnt_nxt = mod_busy ? cyc_cnt + 16'd1 : cyc_cnt;
      cycles_nxt  = mod_cycles;
`endif
      case (state)
         S_IDLE: begin
            if (start_hit_c) begin
               x_nxt    = mod_x;
               y_nxt    = mod_y;
               n_nxt    = mod_n;
               acc_nxt  = '0;
               cnt_nxt  = CNT_W'(W);
               busy_nxt = 1'b1;
`ifdef RSA_MODMUL_CYCLE_CNT_EN
               cyc_cnt_nxt = 16'd0;
`endif
            end
         end
         S_DOUBLE: acc_nxt = red_dbl_c;
         S_ADD: begin
            acc_nxt = red_add_c;
            y_nxt   = {y_reg[W-2:0], 1'b0};
            cnt_nxt = cnt - CNT_W'(1);
         end
         S_DONE: begin
            c_nxt    = acc[W-1:0];
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
`ifdef RSA_MODMUL_CYCLE_CNT_EN
            cycles_nxt = cyc_cnt + 16'd1;
`endif
         end
         S_ERROR: begin
            c_nxt    = '1;
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
            busy_nxt = 1'b0;
`ifdef RSA_MODMUL_CYCLE_CNT_EN
            cycles_nxt = cyc_cnt + 16'd1;
`endif
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge mod_clk or negedge mod_rst) begin
      if (!mod_rst) begin
         x_reg    <= '0;
         y_reg    <= '0;
         n_reg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         mod_busy <= 1'b0;
         mod_done <= 1'b0;
         mod_err  <= 1'b0;
         mod_c    <= '0;
`ifdef RSA_MODMUL_CYCLE_CNT_EN
         cyc_cnt    <= '0;
         mod_cycles <= '0;
`endif
      end else begin
         x_reg    <= x_nxt;
         y_reg    <= y_nxt;
         n_reg    <= n_nxt;
         acc      <= acc_nxt;
         cnt      <= cnt_nxt;
         mod_busy <= busy_nxt;
         mod_done <= done_nxt;
         mod_err  <= err_nxt;
         mod_c    <= c_nxt;
`ifdef RSA_MODMUL_CYCLE_CNT_EN
         cyc_cnt    <= cyc_cnt_nxt;
         mod_cycles <= cycles_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rsa_core_modmul.sv
// Scoreboard bench for rsa_core_modmul: directed vectors push expected completions, a monitor checks them.
module tb_rsa_core_modmul;

   localparam int unsigned W = 8;

   logic         mod_clk   = 1'b0;
   logic         mod_rst   = 1'b0;
   logic         mod_start = 1'b0;
   logic [W-1:0] mod_x     = '0;
   logic [W-1:0] mod_y     = '0;
   logic [W-1:0] mod_n     = '0;
   logic         mod_busy, mod_done, mod_err;
   logic [W-1:0] mod_c;

   logic         s16_start = 1'b0;
   logic [15:0]  s16_x = '0, s16_y = '0, s16_n = '0;
   logic         s16_busy, s16_done, s16_err;
   logic [15:0]  s16_c;

`ifdef RSA_MODMUL_CYCLE_CNT_EN
   logic [15:0] mod_cycles, s16_cycles;
`endif

   rsa_core_modmul #(.DATA_WIDTH(W), .START(1'b1)) u_dut (
      .mod_clk(mod_clk), .mod_rst(mod_rst), .mod_start(mod_start),
      .mod_x(mod_x), .mod_y(mod_y), .mod_n(mod_n),
      .mod_busy(mod_busy), .mod_done(mod_done), .mod_err(mod_err), .mod_c(mod_c)
`ifdef RSA_MODMUL_CYCLE_CNT_EN
      , .mod_cycles(mod_cycles)
`endif
   );

   rsa_core_modmul #(.DATA_WIDTH(16), .START(1'b1)) u_dut16 (
      .mod_clk(mod_clk), .mod_rst(mod_rst), .mod_start(s16_start),
      .mod_x(s16_x), .mod_y(s16_y), .mod_n(s16_n),
      .mod_busy(s16_busy), .mod_done(s16_done), .mod_err(s16_err), .mod_c(s16_c)
`ifdef RSA_MODMUL_CYCLE_CNT_EN
      , .mod_cycles(s16_cycles)
`endif
   );

   typedef struct {
      logic [W-1:0] c;
      logic         err;
      int unsigned  lat;
      int unsigned  done_cyc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;
   int unsigned busy_cnt = 0;

   always #5 mod_clk = ~mod_clk;
   always @(posedge mod_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // Monitor: every completion must match the oldest outstanding expectation
   always @(negedge mod_clk) begin
      exp_t e;
      if (!mod_rst) begin
         busy_cnt = 0;
      end else begin
         if (mod_err) chk("err_implies_done", 32'(mod_done), 32'd1);
         if (mod_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got c=%0d err=%0d required no completion", mod_c, mod_err);
            end else begin
               e = exp_q.pop_front();
               chk("result", 32'(mod_c), 32'(e.c));
               chk("err", 32'(mod_err), 32'(e.err));
               chk("busy_at_done", 32'(mod_busy), 32'd0);
               chk("done_cycle", cyc, e.done_cyc);
               chk("busy_len", busy_cnt, e.lat);
`ifdef RSA_MODMUL_CYCLE_CNT_EN
               chk("mod_cycles", 32'(mod_cycles), e.lat);
`endif
            end
            busy_cnt = 0;
         end else if (mod_busy) begin
            busy_cnt++;
         end
      end
   end

   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] n,
                           input logic [W-1:0] c, input logic err, input bit push);
      exp_t e;
      @(negedge mod_clk);
      mod_x = x; mod_y = y; mod_n = n; mod_start = 1'b1;
      @(posedge mod_clk);
      #1;
      e.c = c; e.err = err; e.lat = err ? 2 : 2 * W + 2; e.done_cyc = cyc + e.lat;
      if (push) exp_q.push_back(e);
      @(negedge mod_clk);
      mod_start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge mod_clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d outstanding required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge mod_clk);
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] n,
                         input logic [W-1:0] c, input logic err);
      start_op(x, y, n, c, err, 1'b1);
      drain();
   endtask

   initial begin
      exp_t e;
      int unsigned a;
      bit seen;

      repeat (3) @(negedge mod_clk);
      chk("rst_busy", 32'(mod_busy), 0);
      chk("rst_done", 32'(mod_done), 0);
      chk("rst_err",  32'(mod_err),  0);
      chk("rst_c",    32'(mod_c),    0);
      mod_rst = 1'b1;
      repeat (2) @(negedge mod_clk);

      run_op(8'd7,   8'd9,   8'd11,  8'd8,   1'b0);
      run_op(8'd250, 8'd249, 8'd251, 8'd2,   1'b0);
      run_op(8'd0,   8'd123, 8'd251, 8'd0,   1'b0);
      run_op(8'd5,   8'd3,   8'd0,   8'hFF,  1'b1);
      run_op(8'd12,  8'd3,   8'd11,  8'hFF,  1'b1);
      run_op(8'd3,   8'd11,  8'd11,  8'hFF,  1'b1);
      run_op(8'd0,   8'd0,   8'd1,   8'd0,   1'b0);
      run_op(8'd10,  8'd10,  8'd11,  8'd1,   1'b0);
      run_op(8'd254, 8'd254, 8'd255, 8'd1,   1'b0);

      // Asynchronous reset mid-operation aborts without a completion
      start_op(8'd7, 8'd9, 8'd11, 8'd8, 1'b0, 1'b0);
      repeat (7) @(posedge mod_clk);
      #1;
      chk("busy_before_abort", 32'(mod_busy), 1);
      #1;
      mod_rst = 1'b0;
      #1;
      chk("abort_busy", 32'(mod_busy), 0);
      chk("abort_done", 32'(mod_done), 0);
      chk("abort_err",  32'(mod_err),  0);
      chk("abort_c",    32'(mod_c),    0);
      repeat (3) @(negedge mod_clk);
      mod_rst = 1'b1;
      repeat (25) @(negedge mod_clk);
      run_op(8'd7, 8'd9, 8'd11, 8'd8, 1'b0);

      // Start held high: second acceptance right after the done cycle
      @(negedge mod_clk);
      mod_x = 8'd3; mod_y = 8'd5; mod_n = 8'd7; mod_start = 1'b1;
      @(posedge mod_clk);
      #1;
      a = cyc;
      e.c = 8'd1; e.err = 1'b0; e.lat = 18; e.done_cyc = a + 18;
      exp_q.push_back(e);
      e.done_cyc = a + 19 + 18;
      exp_q.push_back(e);
      repeat (19) @(posedge mod_clk);
      #1;
      chk("held_restart_busy", 32'(mod_busy), 1);
      @(negedge mod_clk);
      mod_start = 1'b0;
      drain();

      // Start toggled mid-operation with different operands is ignored
      start_op(8'd7, 8'd9, 8'd11, 8'd8, 1'b0, 1'b1);
      repeat (4) @(negedge mod_clk);
      mod_x = 8'd1; mod_y = 8'd1; mod_n = 8'd2; mod_start = 1'b1;
      @(negedge mod_clk);
      mod_start = 1'b0;
      repeat (3) @(negedge mod_clk);
      mod_start = 1'b1;
      @(negedge mod_clk);
      mod_start = 1'b0;
      drain();
      repeat (25) @(negedge mod_clk);

      // Wide instance: 0xFFFE * 0xFFFD mod 0xFFFF = 2
      @(negedge mod_clk);
      s16_x = 16'hFFFE; s16_y = 16'hFFFD; s16_n = 16'hFFFF; s16_start = 1'b1;
      @(posedge mod_clk);
      #1;
      a = cyc;
      @(negedge mod_clk);
      s16_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (s16_done) begin
            seen = 1'b1;
            chk("w16_result", 32'(s16_c), 32'd2);
            chk("w16_err", 32'(s16_err), 0);
            chk("w16_latency", cyc - a, 34);
`ifdef RSA_MODMUL_CYCLE_CNT_EN
            chk("w16_cycles", 32'(s16_cycles), 34);
`endif
         end else begin
            @(negedge mod_clk);
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL w16_timeout: got no done required done within 100 cycles");
      end

      repeat (3) @(negedge mod_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
